// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared control encodings for the fetch stage and next-PC logic
package fetch_unit_pkg;
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DROP  = 2'd2
   } fetch_state_t;
   typedef enum logic [1:0] {
      NPC_PC4  = 2'd0,
      NPC_BR   = 2'd1,
      NPC_JAL  = 2'd2,
      NPC_JALR = 2'd3
   } npc_sel_t;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus
interface fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;
   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load enable and flush-to-NOP
module if_id_reg
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] NOP_INST = DEF_NOP_INST
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_flush,
   input  logic        i_valid,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_inst,
   output logic        o_valid,
   output logic [31:0] o_pc,
   output logic [31:0] o_inst
);
   logic        r_valid;
   logic [31:0] r_pc, r_inst;
   // flush beats load; a load with i_valid low is a bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_inst  <= NOP_INST;
      end else if (i_flush) begin
         r_valid <= 1'b0;
         r_inst  <= NOP_INST;
      end else if (i_load) begin
         r_valid <= i_valid;
         r_pc    <= i_pc;
         r_inst  <= i_inst;
      end
   end
   assign o_valid = r_valid;
   assign o_pc    = r_pc;
   assign o_inst  = r_inst;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM with hold buffer, stale-response drop and IF/ID register
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] NOP_INST = DEF_NOP_INST
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] npc_in,
   input  logic        redirect,
   input  logic        pc_write,
   input  logic        if_id_write,
   fetch_unit_if.master imem,
   output logic [31:0] pc_out,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_valid
);
   fetch_state_t r_state, w_next;
   logic [31:0]  r_pc, r_req_addr, r_hold_pc, r_hold_inst;
   logic         w_in_hold, w_redir, w_adv, w_to_hold, w_issue, w_req;
   assign w_in_hold = r_state == S_HOLD;
   assign w_redir   = redirect & pc_write;
   // a word moves into IF/ID either straight from memory or from the hold buffer
   assign w_adv     = ~w_redir & if_id_write & pc_write & (w_in_hold | (r_state == S_FETCH & imem.ack));
   assign w_to_hold = ~w_redir & ~w_adv & (r_state == S_FETCH) & imem.ack;
   // a fresh request starts whenever the current one retires into FETCH or HOLD is released
   assign w_issue   = w_in_hold ? (w_adv | w_redir) : (imem.ack & ~w_to_hold);
   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end
   // next state: an unanswered request at redirect time must be drained in DROP
   always_comb begin
      w_next = w_redir   ? ((~w_in_hold & ~imem.ack) ? S_DROP : S_FETCH) :
               w_to_hold ? S_HOLD :
               w_issue   ? S_FETCH : r_state;
   end
   // outputs: request is live in FETCH and DROP, never during reset
   always_comb begin
      w_req = ~rst & ~w_in_hold;
   end
   // PC, request address and hold buffer; a drained DROP resumes at the latest pc_out
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc        <= RESET_PC;
         r_req_addr  <= RESET_PC;
         r_hold_pc   <= '0;
         r_hold_inst <= '0;
      end else begin
         if (w_redir | w_adv) r_pc <= npc_in;
         if (w_issue) r_req_addr <= (r_state == S_DROP & ~w_redir) ? r_pc : npc_in;
         if (w_to_hold) begin
            r_hold_pc   <= r_req_addr;
            r_hold_inst <= imem.rdata;
         end
      end
   end
   assign imem.req  = w_req;
   assign imem.addr = r_req_addr;
   assign pc_out    = r_pc;
   if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
      .clk     (clk),
      .rst     (rst),
      .i_load  (if_id_write),
      .i_flush (w_redir),
      .i_valid (w_adv),
      .i_pc    (w_in_hold ? r_hold_pc : r_req_addr),
      .i_inst  (w_in_hold ? r_hold_inst : imem.rdata),
      .o_valid (if_valid),
      .o_pc    (if_pc),
      .o_inst  (if_inst)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario checks for fetch_unit
module tb_fetch_unit;
   localparam logic [31:0] K = 32'hA5A5_0000;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic        pc_write = 1'b1;
   logic        if_id_write = 1'b1;
   logic        ack_en = 1'b1;
   logic        use_tgt = 1'b0;
   logic [31:0] tgt = '0;
   logic [31:0] npc_in, pc_out, if_pc, if_inst;
   logic        if_valid;
   int          n_chk = 0;
   int          n_fail = 0;
   fetch_unit_if bus ();
   assign bus.ack   = ack_en & bus.req;
   assign bus.rdata = bus.addr ^ K;
   assign npc_in    = use_tgt ? tgt : pc_out + 32'd4;
   always #5 clk = ~clk;
   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .npc_in      (npc_in),
      .redirect    (redirect),
      .pc_write    (pc_write),
      .if_id_write (if_id_write),
      .imem        (bus.master),
      .pc_out      (pc_out),
      .if_pc       (if_pc),
      .if_inst     (if_inst),
      .if_valid    (if_valid)
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1; ack_en = 1'b1; redirect = 1'b0; pc_write = 1'b1;
      if_id_write = 1'b1; use_tgt = 1'b0; tgt = '0;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask
   task automatic test_reset();
      step();
      step();
      n_chk++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h exp %h", pc_out, 32'h0); end
      n_chk++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", if_valid); end
      n_chk++; if (if_inst !== 32'h13) begin n_fail++; $display("FAIL rst_inst got %h exp 00000013", if_inst); end
      n_chk++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_ifpc got %h exp 0", if_pc); end
      n_chk++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", bus.req); end
      rst = 1'b0;
      #1;
      n_chk++; if (bus.req !== 1'b1) begin n_fail++; $display("FAIL post_rst_req got %b exp 1", bus.req); end
      n_chk++; if (bus.addr !== 32'h0) begin n_fail++; $display("FAIL post_rst_addr got %h exp 0", bus.addr); end
   endtask
   task automatic test_sequential();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step();
         n_chk++; if (if_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_ifpc[%0d] got %h exp %h", i, if_pc, 32'(4 * i)); end
         n_chk++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d] got %b exp 1", i, if_valid); end
         n_chk++; if (if_inst !== (32'(4 * i) ^ K)) begin n_fail++; $display("FAIL seq_inst[%0d] got %h exp %h", i, if_inst, 32'(4 * i) ^ K); end
         n_chk++; if (bus.addr !== 32'(4 * i + 4)) begin n_fail++; $display("FAIL seq_addr[%0d] got %h exp %h", i, bus.addr, 32'(4 * i + 4)); end
      end
   endtask
   task automatic test_stall();
      do_reset();
      step();
      step();
      n_chk++; if (if_pc !== 32'h4) begin n_fail++; $display("FAIL stall_pre_ifpc got %h exp 4", if_pc); end
      if_id_write = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_chk++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d] got %b exp 0", i, bus.req); end
         n_chk++; if (if_pc !== 32'h4) begin n_fail++; $display("FAIL stall_ifpc[%0d] got %h exp 4", i, if_pc); end
         n_chk++; if (pc_out !== 32'h8) begin n_fail++; $display("FAIL stall_pc[%0d] got %h exp 8", i, pc_out); end
      end
      if_id_write = 1'b1;
      step();
      n_chk++; if (if_pc !== 32'h8) begin n_fail++; $display("FAIL release_ifpc got %h exp 8", if_pc); end
      n_chk++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL release_valid got %b exp 1", if_valid); end
      n_chk++; if (if_inst !== (32'h8 ^ K)) begin n_fail++; $display("FAIL release_inst got %h exp %h", if_inst, 32'h8 ^ K); end
      n_chk++; if (bus.addr !== 32'hC) begin n_fail++; $display("FAIL release_addr got %h exp c", bus.addr); end
      n_chk++; if (bus.req !== 1'b1) begin n_fail++; $display("FAIL release_req got %b exp 1", bus.req); end
      step();
      n_chk++; if (if_pc !== 32'hC) begin n_fail++; $display("FAIL release_next_ifpc got %h exp c", if_pc); end
   endtask
   task automatic test_redirect_drop();
      do_reset();
      for (int i = 0; i < 4; i++) step();
      n_chk++; if (bus.addr !== 32'h10) begin n_fail++; $display("FAIL drop_pre_addr got %h exp 10", bus.addr); end
      ack_en = 1'b0; redirect = 1'b1; use_tgt = 1'b1; tgt = 32'h100;
      step();
      redirect = 1'b0; use_tgt = 1'b0;
      n_chk++; if (pc_out !== 32'h100) begin n_fail++; $display("FAIL drop_pc got %h exp 100", pc_out); end
      n_chk++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid0 got %b exp 0", if_valid); end
      n_chk++; if (if_inst !== 32'h13) begin n_fail++; $display("FAIL drop_inst got %h exp 00000013", if_inst); end
      n_chk++; if (bus.addr !== 32'h10) begin n_fail++; $display("FAIL drop_addr0 got %h exp 10", bus.addr); end
      n_chk++; if (bus.req !== 1'b1) begin n_fail++; $display("FAIL drop_req got %b exp 1", bus.req); end
      step();
      n_chk++; if (bus.addr !== 32'h10) begin n_fail++; $display("FAIL drop_addr1 got %h exp 10", bus.addr); end
      n_chk++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid1 got %b exp 0", if_valid); end
      ack_en = 1'b1;
      step();
      n_chk++; if (bus.addr !== 32'h100) begin n_fail++; $display("FAIL drop_new_addr got %h exp 100", bus.addr); end
      n_chk++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid2 got %b exp 0", if_valid); end
      n_chk++; if (pc_out !== 32'h100) begin n_fail++; $display("FAIL drop_pc2 got %h exp 100", pc_out); end
      step();
      n_chk++; if (if_pc !== 32'h100) begin n_fail++; $display("FAIL drop_ifpc got %h exp 100", if_pc); end
      n_chk++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL drop_valid3 got %b exp 1", if_valid); end
      n_chk++; if (if_inst !== (32'h100 ^ K)) begin n_fail++; $display("FAIL drop_inst3 got %h exp %h", if_inst, 32'h100 ^ K); end
   endtask
   task automatic test_redirect_ack();
      do_reset();
      for (int i = 0; i < 5; i++) step();
      n_chk++; if (bus.addr !== 32'h14) begin n_fail++; $display("FAIL rack_pre_addr got %h exp 14", bus.addr); end
      redirect = 1'b1; use_tgt = 1'b1; tgt = 32'h200;
      step();
      redirect = 1'b0; use_tgt = 1'b0;
      n_chk++; if (bus.addr !== 32'h200) begin n_fail++; $display("FAIL rack_addr got %h exp 200", bus.addr); end
      n_chk++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rack_valid got %b exp 0", if_valid); end
      n_chk++; if (pc_out !== 32'h200) begin n_fail++; $display("FAIL rack_pc got %h exp 200", pc_out); end
      step();
      n_chk++; if (if_pc !== 32'h200) begin n_fail++; $display("FAIL rack_ifpc got %h exp 200", if_pc); end
      n_chk++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL rack_valid1 got %b exp 1", if_valid); end
   endtask
   task automatic test_reset_in_hold();
      do_reset();
      step();
      step();
      if_id_write = 1'b0;
      step();
      n_chk++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL rhold_req got %b exp 0", bus.req); end
      rst = 1'b1;
      step();
      n_chk++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rhold_pc got %h exp 0", pc_out); end
      n_chk++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rhold_valid got %b exp 0", if_valid); end
      n_chk++; if (if_inst !== 32'h13) begin n_fail++; $display("FAIL rhold_inst got %h exp 00000013", if_inst); end
      rst = 1'b0; if_id_write = 1'b1;
      #1;
      n_chk++; if (bus.req !== 1'b1) begin n_fail++; $display("FAIL rhold_req1 got %b exp 1", bus.req); end
      n_chk++; if (bus.addr !== 32'h0) begin n_fail++; $display("FAIL rhold_addr got %h exp 0", bus.addr); end
      step();
      n_chk++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rhold_ifpc got %h exp 0", if_pc); end
      n_chk++; if (if_inst !== K) begin n_fail++; $display("FAIL rhold_ifinst got %h exp %h", if_inst, K); end
   endtask
   task automatic test_redirect_no_pcwrite();
      do_reset();
      step();
      step();
      ack_en = 1'b0; pc_write = 1'b0; if_id_write = 1'b0; redirect = 1'b1; use_tgt = 1'b1; tgt = 32'h300;
      step();
      n_chk++; if (pc_out !== 32'h8) begin n_fail++; $display("FAIL nopw_pc got %h exp 8", pc_out); end
      n_chk++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL nopw_valid got %b exp 1", if_valid); end
      n_chk++; if (if_pc !== 32'h4) begin n_fail++; $display("FAIL nopw_ifpc got %h exp 4", if_pc); end
      n_chk++; if (bus.addr !== 32'h8) begin n_fail++; $display("FAIL nopw_addr got %h exp 8", bus.addr); end
      ack_en = 1'b1; pc_write = 1'b1; if_id_write = 1'b1; redirect = 1'b0; use_tgt = 1'b0;
      step();
      n_chk++; if (if_pc !== 32'h8) begin n_fail++; $display("FAIL nopw_next_ifpc got %h exp 8", if_pc); end
      n_chk++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL nopw_next_valid got %b exp 1", if_valid); end
   endtask
   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_drop();
      test_redirect_ack();
      test_reset_in_hold();
      test_redirect_no_pcwrite();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
